// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard / stall controller.
package hazard_pkg;

   // Controller state: free-running or counting down extra load-use bubbles.
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_LU_STALL = 1'b1
   } state_e;

   // Value driven on control_sel when a bubble (zeroed control) enters ID/EX.
   localparam logic CONTROL_BUBBLE = 1'b0;
   localparam logic CONTROL_PASS   = 1'b1;

   // One bundle of all pipeline steering outputs.
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic ex_mem_write;
      logic control_sel;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_t;

   // Normal flow: everything advances, nothing is cleared.
   localparam ctrl_t CTRL_RUN = '{
      pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
      control_sel: CONTROL_PASS, if_id_flush: 1'b0, id_ex_flush: 1'b0};

   // Data memory busy: the whole front of the pipe holds still.
   localparam ctrl_t CTRL_FREEZE = '{
      pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
      control_sel: CONTROL_PASS, if_id_flush: 1'b0, id_ex_flush: 1'b0};

   // Taken branch: advance, but squash the two wrong-path instructions.
   localparam ctrl_t CTRL_FLUSH = '{
      pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
      control_sel: CONTROL_PASS, if_id_flush: 1'b1, id_ex_flush: 1'b1};

   // Load-use bubble: hold PC and IF/ID, push a zero-control slot into EX.
   localparam ctrl_t CTRL_BUBBLE = '{
      pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1, ex_mem_write: 1'b1,
      control_sel: CONTROL_BUBBLE, if_id_flush: 1'b0, id_ex_flush: 1'b0};

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear first, then increment unless already all-ones.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use bubbles, memory-wait freeze,
// branch flush, sticky memory-timeout error and a stall-cycle counter.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned LU_BUBBLES  = 1,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_ex_memread,
   input  logic [REG_AW-1:0] id_ex_register_rd,
   input  logic [REG_AW-1:0] if_id_register_rs1,
   input  logic [REG_AW-1:0] if_id_register_rs2,
   input  logic              if_id_uses_rs1,
   input  logic              if_id_uses_rs2,
   input  logic              ex_mem_memop,
   input  logic              mem_ready,
   input  logic              branch_taken,
   input  logic              stall_clr,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_write,
   output logic              ex_mem_write,
   output logic              control_sel,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  stall_count
);

   // Wide enough to hold MEM_TIMEOUT so the terminal value is reachable.
   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   // The detection cycle is the first bubble; the rest come from LU_STALL.
   localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

   state_e            state_q;
   state_e            state_d;
   logic [1:0]        lu_cnt_q;
   logic [1:0]        lu_cnt_d;
   logic              mem_timeout_q;
   logic              mem_timeout_d;
   logic [WAIT_W-1:0] wait_cnt;
   logic              rs1_hit;
   logic              rs2_hit;
   logic              hazard;
   logic              mem_wait;
   ctrl_t             ctrl;
   ctrl_t             ctrl_out;

   // Load-use detection; sources the ID instruction does not read are ignored.
   always_comb begin
      rs1_hit  = if_id_uses_rs1 && (if_id_register_rs1 == id_ex_register_rd);
      rs2_hit  = if_id_uses_rs2 && (if_id_register_rs2 == id_ex_register_rd);
      hazard   = id_ex_memread && (id_ex_register_rd != '0) && (rs1_hit || rs2_hit);
      mem_wait = ex_mem_memop && !mem_ready;
   end

   // Priority arbitration of the four events and bubble-countdown next state.
   always_comb begin
      ctrl     = CTRL_RUN;
      state_d  = state_q;
      lu_cnt_d = lu_cnt_q;
      if (mem_wait) begin
         // Freeze: the bubble countdown pauses and resumes afterwards.
         ctrl = CTRL_FREEZE;
      end else if (branch_taken) begin
         // Any pending dependent instruction is on the wrong path.
         ctrl     = CTRL_FLUSH;
         state_d  = ST_RUN;
         lu_cnt_d = 2'd0;
      end else if (state_q == ST_LU_STALL) begin
         ctrl = CTRL_BUBBLE;
         if (lu_cnt_q == 2'd1) begin
            state_d  = ST_RUN;
            lu_cnt_d = 2'd0;
         end else begin
            lu_cnt_d = lu_cnt_q - 2'd1;
         end
      end else if (hazard) begin
         ctrl = CTRL_BUBBLE;
         if (LU_BUBBLES > 32'd1) begin
            state_d  = ST_LU_STALL;
            lu_cnt_d = LU_INIT;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         ctrl = CTRL_RUN;
      end
   end

   // Reset forces the pass-through outputs regardless of inputs.
   always_comb begin
      if (rst) begin
         ctrl_out = CTRL_RUN;
      end else begin
         ctrl_out = ctrl;
      end
   end

   // Timeout sets on the last allowed wait cycle and is held until reset.
   always_comb begin
      if (mem_wait && (wait_cnt == WAIT_LAST)) begin
         mem_timeout_d = 1'b1;
      end else begin
         mem_timeout_d = mem_timeout_q;
      end
   end

   // FSM, bubble counter and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         lu_cnt_q      <= 2'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lu_cnt_q      <= lu_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Consecutive memory-wait cycles; any non-wait cycle restarts it.
   sat_counter #(
      .W (WAIT_W)
   ) u_wait_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (!mem_wait),
      .inc_i   (mem_wait),
      .count_o (wait_cnt)
   );

   // Performance counter of cycles in which the PC was held.
   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (stall_clr),
      .inc_i   (!ctrl_out.pc_write),
      .count_o (stall_count)
   );

   assign pc_write     = ctrl_out.pc_write;
   assign if_id_write  = ctrl_out.if_id_write;
   assign id_ex_write  = ctrl_out.id_ex_write;
   assign ex_mem_write = ctrl_out.ex_mem_write;
   assign control_sel  = ctrl_out.control_sel;
   assign if_id_flush  = ctrl_out.if_id_flush;
   assign id_ex_flush  = ctrl_out.id_ex_flush;
   assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controller instances (1 and 2 bubbles) share stimulus.
module tb_hazard_stall_ctrl;

   // ctrl bit order: pc, if_id_w, id_ex_w, ex_mem_w, control_sel, if_id_fl, id_ex_fl
   localparam logic [6:0] E_RUN    = 7'b1111100;
   localparam logic [6:0] E_FREEZE = 7'b0000100;
   localparam logic [6:0] E_FLUSH  = 7'b1111111;
   localparam logic [6:0] E_BUBBLE = 7'b0011000;

   logic       clk = 1'b0;
   logic       rst;
   logic       memread;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       u1;
   logic       u2;
   logic       memop;
   logic       ready;
   logic       br;
   logic       clr;

   logic [6:0] ctrl_a;
   logic [6:0] ctrl_b;
   logic       to_a;
   logic       to_b;
   logic [7:0] cnt_a;
   logic [3:0] cnt_b;

   typedef struct {
      logic [6:0] ctrl;
      logic       to;
      int         cnt;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int lb[2]   = '{1, 2};
   int mt[2]   = '{6, 4};
   int cmax[2] = '{255, 15};
   int m_lu[2];
   int m_wait[2];
   int m_cnt[2];
   bit m_to[2];

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .REG_AW (5), .LU_BUBBLES (1), .MEM_TIMEOUT (6), .CNT_W (8)
   ) u_dut_a (
      .clk (clk), .rst (rst),
      .id_ex_memread (memread), .id_ex_register_rd (rd),
      .if_id_register_rs1 (rs1), .if_id_register_rs2 (rs2),
      .if_id_uses_rs1 (u1), .if_id_uses_rs2 (u2),
      .ex_mem_memop (memop), .mem_ready (ready),
      .branch_taken (br), .stall_clr (clr),
      .pc_write (ctrl_a[6]), .if_id_write (ctrl_a[5]), .id_ex_write (ctrl_a[4]),
      .ex_mem_write (ctrl_a[3]), .control_sel (ctrl_a[2]),
      .if_id_flush (ctrl_a[1]), .id_ex_flush (ctrl_a[0]),
      .mem_timeout (to_a), .stall_count (cnt_a)
   );

   hazard_stall_ctrl #(
      .REG_AW (5), .LU_BUBBLES (2), .MEM_TIMEOUT (4), .CNT_W (4)
   ) u_dut_b (
      .clk (clk), .rst (rst),
      .id_ex_memread (memread), .id_ex_register_rd (rd),
      .if_id_register_rs1 (rs1), .if_id_register_rs2 (rs2),
      .if_id_uses_rs1 (u1), .if_id_uses_rs2 (u2),
      .ex_mem_memop (memop), .mem_ready (ready),
      .branch_taken (br), .stall_clr (clr),
      .pc_write (ctrl_b[6]), .if_id_write (ctrl_b[5]), .id_ex_write (ctrl_b[4]),
      .ex_mem_write (ctrl_b[3]), .control_sel (ctrl_b[2]),
      .if_id_flush (ctrl_b[1]), .id_ex_flush (ctrl_b[0]),
      .mem_timeout (to_b), .stall_count (cnt_b)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_hz();
      return memread && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
   endfunction

   function automatic logic [6:0] model_ctrl(input int k);
      if (rst) return E_RUN;
      if (memop && !ready) return E_FREEZE;
      if (br) return E_FLUSH;
      if (m_lu[k] > 0 || model_hz()) return E_BUBBLE;
      return E_RUN;
   endfunction

   // One clock: predict, compare at negedge, advance the model at posedge.
   task automatic step();
      exp_t       e;
      logic [6:0] ctl;
      for (int k = 0; k < 2; k++) begin
         e.ctrl = model_ctrl(k);
         e.to   = rst ? 1'b0 : m_to[k];
         e.cnt  = rst ? 0 : m_cnt[k];
         exp_q.push_back(e);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      check_val($sformatf("c%0d a ctrl", cyc), {25'd0, ctrl_a}, {25'd0, e.ctrl});
      check_val($sformatf("c%0d a to", cyc), {31'd0, to_a}, {31'd0, e.to});
      check_val($sformatf("c%0d a cnt", cyc), {24'd0, cnt_a}, e.cnt);
      e = exp_q.pop_front();
      check_val($sformatf("c%0d b ctrl", cyc), {25'd0, ctrl_b}, {25'd0, e.ctrl});
      check_val($sformatf("c%0d b to", cyc), {31'd0, to_b}, {31'd0, e.to});
      check_val($sformatf("c%0d b cnt", cyc), {28'd0, cnt_b}, e.cnt);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         ctl = model_ctrl(k);
         if (rst) begin
            m_lu[k] = 0; m_wait[k] = 0; m_cnt[k] = 0; m_to[k] = 1'b0;
         end else begin
            if (clr) m_cnt[k] = 0;
            else if (!ctl[6] && m_cnt[k] < cmax[k]) m_cnt[k]++;
            if (memop && !ready) begin
               if (m_wait[k] == mt[k] - 1) m_to[k] = 1'b1;
               m_wait[k]++;
            end else begin
               m_wait[k] = 0;
               if (br) m_lu[k] = 0;
               else if (m_lu[k] > 0) m_lu[k]--;
               else if (model_hz()) m_lu[k] = lb[k] - 1;
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle();
      memread = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
      memop = 1'b0; ready = 1'b1; br = 1'b0; clr = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] r, input logic [4:0] a, input logic ua,
                           input logic [4:0] b, input logic ub);
      memread = 1'b1; rd = r; rs1 = a; u1 = ua; rs2 = b; u2 = ub;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      step(); step();
      rst = 1'b0;
      step();

      // rs1 load-use, then the bubble reaches EX.
      load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); step();
      memread = 1'b0; step();
      idle(); step();
      // rd = x0 never stalls.
      load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); step();
      // rs2 match with uses_rs2, then without.
      load_use(5'd7, 5'd1, 1'b1, 5'd7, 1'b1); step();
      memread = 1'b0; step();
      idle(); step();
      load_use(5'd7, 5'd1, 1'b1, 5'd7, 1'b0); step();
      idle(); step();

      // Memory wait inside LU_STALL pauses the countdown.
      load_use(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); step();
      memread = 1'b0; memop = 1'b1; ready = 1'b0;
      repeat (3) step();
      memop = 1'b0; ready = 1'b1; step();
      idle(); step();

      // Branch with a simultaneous hazard, then branch inside LU_STALL.
      load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); br = 1'b1; step();
      idle(); step();
      load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); step();
      memread = 1'b0; br = 1'b1; step();
      idle(); step();

      // Timeout: six wait cycles, then sticky.
      memop = 1'b1; ready = 1'b0;
      repeat (6) step();
      ready = 1'b1; step();
      idle(); step(); step();
      check_val("to_sticky_b", {31'd0, to_b}, 32'd1);
      check_val("to_sticky_a", {31'd0, to_a}, 32'd1);

      // Saturation and clear-beats-increment.
      clr = 1'b1; step();
      clr = 1'b0; memop = 1'b1; ready = 1'b0;
      repeat (20) step();
      check_val("sat_b", {28'd0, cnt_b}, 32'd15);
      clr = 1'b1; step();
      check_val("clr_b", {28'd0, cnt_b}, 32'd0);
      idle(); step();

      // Reset in the middle of LU_STALL.
      load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); step();
      rst = 1'b1;
      #1;
      check_val("rst_mid_b_ctrl", {25'd0, ctrl_b}, {25'd0, E_RUN});
      step();
      rst = 1'b0; idle(); step();
      check_val("rst_to_b", {31'd0, to_b}, 32'd0);

      // Random mix of all events.
      for (int i = 0; i < 300; i++) begin
         memread = 1'($urandom_range(0, 1));
         rd      = 5'($urandom_range(0, 3));
         rs1     = 5'($urandom_range(0, 3));
         rs2     = 5'($urandom_range(0, 3));
         u1      = 1'($urandom_range(0, 1));
         u2      = 1'($urandom_range(0, 1));
         memop   = ($urandom_range(0, 3) == 0);
         ready   = 1'($urandom_range(0, 1));
         br      = ($urandom_range(0, 7) == 0);
         clr     = ($urandom_range(0, 15) == 0);
         rst     = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0; idle(); step();

      check_val("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
